// File: rtl/serial_flow_adder.sv
// rtl/serial_flow_adder.sv - multi-lane LSB-first bit-serial adder with word framing and overflow flags
// Words are framed by in_first; each lane adds its own operand pair with a private carry.
module serial_flow_adder #(
  parameter int LANES  = 2,
  parameter int WORD_W = 8,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic [LANES-1:0] line1,
  input  logic [LANES-1:0] line2,
  output logic [LANES-1:0] outp,
  output logic             out_valid,
  output logic             out_last,
  output logic [LANES-1:0] overflw,
  output logic             word_err
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_W - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [LANES-1:0] carry;

  logic             accept;
  logic             last_bit;
  logic             frame_err;
  logic [CW-1:0]    idx;
  logic [LANES-1:0] cin;
  logic [LANES-1:0] sum_bit;
  logic [LANES-1:0] cout;

  // A new in_first always restarts at index 0 with a clean carry, even mid-word.
  always_comb begin
    accept    = in_valid && ((state == RUN) || in_first);
    idx       = in_first ? '0 : cnt;
    cin       = in_first ? '0 : carry;
    last_bit  = accept && (idx == LAST_IDX);
    frame_err = in_valid && ((in_first && (state == RUN)) || (!in_first && (state == IDLE)));
    sum_bit   = line1 ^ line2 ^ cin;
    cout      = (line1 & line2) | (line1 & cin) | (line2 & cin);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= '0;
      outp      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflw   <= '0;
      word_err  <= 1'b0;
    end else begin
      out_valid <= accept;
      out_last  <= last_bit;
      word_err  <= frame_err;
      if (accept) begin
        outp <= sum_bit;
        if (last_bit) begin
          state   <= IDLE;
          cnt     <= '0;
          carry   <= '0;
          // Signed overflow is the carry into the sign bit differing from the carry out.
          overflw <= (SIGNED != 0) ? (cin ^ cout) : cout;
        end else begin
          state <= RUN;
          cnt   <= idx + CW'(1);
          carry <= cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_flow_adder.sv
// tb/tb_serial_flow_adder.sv - randomized self-checking bench for serial_flow_adder (unsigned and signed)
module tb_serial_flow_adder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_first;
  logic [1:0] line1;
  logic [1:0] line2;

  logic [1:0] u_outp, u_ovf, s_outp, s_ovf;
  logic       u_valid, u_last, u_err, s_valid, s_last, s_err;

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_ovu = 2'b00;
  logic [1:0] exp_ovs = 2'b00;
  logic [1:0] exp_outp = 2'b00;

  always #5 clock = ~clock;

  serial_flow_adder #(.LANES(2), .WORD_W(4), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .line1(line1), .line2(line2), .outp(u_outp), .out_valid(u_valid),
    .out_last(u_last), .overflw(u_ovf), .word_err(u_err)
  );

  serial_flow_adder #(.LANES(2), .WORD_W(4), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_first(in_first),
    .line1(line1), .line2(line2), .outp(s_outp), .out_valid(s_valid),
    .out_last(s_last), .overflw(s_ovf), .word_err(s_err)
  );

  task automatic step(input logic v, input logic f, input logic [1:0] a, input logic [1:0] b);
    @(negedge clock);
    in_valid = v;
    in_first = f;
    line1    = a;
    line2    = b;
    @(posedge clock);
    #1;
  endtask

  // Reference: whole-word integer addition; bit i of the sum is the i-th serial output.
  task automatic send_word(input logic [7:0] a_all, input logic [7:0] b_all, input int fix_bit,
                           input int fix_n, input int rand_max, input logic err_first);
    logic [4:0] sum [2];
    logic [1:0] ovu, ovs;
    logic [3:0] wa, wb;
    int n;
    for (int l = 0; l < 2; l++) begin
      wa = a_all[l*4 +: 4];
      wb = b_all[l*4 +: 4];
      sum[l] = {1'b0, wa} + {1'b0, wb};
      ovu[l] = sum[l][4];
      ovs[l] = (wa[3] == wb[3]) && (sum[l][3] != wa[3]);
    end
    for (int i = 0; i < 4; i++) begin
      n = (i == fix_bit) ? fix_n : ((i > 0 && rand_max > 0) ? int'($urandom_range(0, rand_max)) : 0);
      for (int k = 0; k < n; k++) begin
        step(1'b0, 1'($urandom), 2'($urandom), 2'($urandom));
        checks++;
        if ({u_valid, u_last, u_err, s_valid, s_last, s_err} !== 6'b0 ||
            u_outp !== exp_outp || s_outp !== exp_outp ||
            u_ovf !== exp_ovu || s_ovf !== exp_ovs) begin
          errors++;
          $display("FAIL stall bit%0d: got v/l/e u=%b%b%b s=%b%b%b outp u=%b s=%b ovf u=%b s=%b, want 000 outp=%b ovf u=%b s=%b",
                   i, u_valid, u_last, u_err, s_valid, s_last, s_err, u_outp, s_outp, u_ovf, s_ovf,
                   exp_outp, exp_ovu, exp_ovs);
        end
      end
      step(1'b1, (i == 0), {a_all[4+i], a_all[i]}, {b_all[4+i], b_all[i]});
      exp_outp = {sum[1][i], sum[0][i]};
      if (i == 3) begin
        exp_ovu = ovu;
        exp_ovs = ovs;
      end
      checks++;
      if (u_valid !== 1'b1 || s_valid !== 1'b1 || u_last !== (i == 3) || s_last !== (i == 3) ||
          u_err !== (err_first && i == 0) || s_err !== (err_first && i == 0) ||
          u_outp !== exp_outp || s_outp !== exp_outp ||
          u_ovf !== exp_ovu || s_ovf !== exp_ovs) begin
        errors++;
        $display("FAIL word bit%0d a=%h b=%h: got v/l/e u=%b%b%b s=%b%b%b outp u=%b s=%b ovf u=%b s=%b, want 1%b%b outp=%b ovf u=%b s=%b",
                 i, a_all, b_all, u_valid, u_last, u_err, s_valid, s_last, s_err, u_outp, s_outp,
                 u_ovf, s_ovf, (i == 3), (err_first && i == 0), exp_outp, exp_ovu, exp_ovs);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({u_outp, u_valid, u_last, u_ovf, u_err, s_outp, s_valid, s_last, s_ovf, s_err} !== 14'b0) begin
      errors++;
      $display("FAIL %s: got u outp=%b v=%b l=%b ovf=%b e=%b s outp=%b v=%b l=%b ovf=%b e=%b, want all 0",
               name, u_outp, u_valid, u_last, u_ovf, u_err, s_outp, s_valid, s_last, s_ovf, s_err);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    in_first = 1'b0;
    line1    = 2'b00;
    line2    = 2'b00;
    #12;
    check_all_zero("reset_state");
    @(negedge clock);
    reset = 1'b1;
    exp_ovu = 2'b00;
    exp_ovs = 2'b00;
    exp_outp = 2'b00;
  endtask

  task automatic test_known_vector();
    send_word({4'hF, 4'h7}, {4'h1, 4'h1}, -1, 0, 0, 1'b0);
    checks++;
    if (u_ovf !== 2'b10 || s_ovf !== 2'b01) begin
      errors++;
      $display("FAIL known_vector_ovf: got u=%b s=%b, want u=10 s=01", u_ovf, s_ovf);
    end
    step(1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic test_stall();
    send_word({4'hF, 4'h7}, {4'h1, 4'h1}, 3, 3, 0, 1'b0);
    checks++;
    if (u_ovf !== 2'b10 || s_ovf !== 2'b01) begin
      errors++;
      $display("FAIL stall_ovf: got u=%b s=%b, want u=10 s=01", u_ovf, s_ovf);
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b1, 2'b11, 2'b11);
    step(1'b1, 1'b0, 2'b11, 2'b01);
    checks++;
    if (u_valid !== 1'b1 || u_last !== 1'b0 || u_err !== 1'b0 || s_err !== 1'b0 ||
        u_ovf !== exp_ovu || s_ovf !== exp_ovs) begin
      errors++;
      $display("FAIL abort_prefix: got v=%b l=%b e u=%b s=%b ovf u=%b s=%b, want 1 0 0 0 ovf u=%b s=%b",
               u_valid, u_last, u_err, s_err, u_ovf, s_ovf, exp_ovu, exp_ovs);
    end
    send_word(8'h00, 8'h00, -1, 0, 0, 1'b1);
    checks++;
    if (u_ovf !== 2'b00 || s_ovf !== 2'b00) begin
      errors++;
      $display("FAIL abort_ovf: got u=%b s=%b, want 00", u_ovf, s_ovf);
    end
  endtask

  task automatic test_stray();
    step(1'b1, 1'b0, 2'($urandom), 2'($urandom));
    checks++;
    if (u_valid !== 1'b0 || s_valid !== 1'b0 || u_err !== 1'b1 || s_err !== 1'b1 ||
        u_ovf !== exp_ovu || s_ovf !== exp_ovs) begin
      errors++;
      $display("FAIL stray_bit: got v u=%b s=%b e u=%b s=%b ovf u=%b s=%b, want v=0 e=1 ovf u=%b s=%b",
               u_valid, s_valid, u_err, s_err, u_ovf, s_ovf, exp_ovu, exp_ovs);
    end
    step(1'b0, 1'b0, 2'b00, 2'b00);
    checks++;
    if (u_err !== 1'b0 || s_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_pulse_width: got e u=%b s=%b, want 0", u_err, s_err);
    end
  endtask

  task automatic test_reset_mid();
    send_word({4'h9, 4'hE}, {4'hB, 4'h5}, -1, 0, 0, 1'b0);
    step(1'b1, 1'b1, 2'b11, 2'b11);
    step(1'b1, 1'b0, 2'b11, 2'b10);
    reset = 1'b0;
    #1;
    check_all_zero("reset_mid_word");
    exp_ovu = 2'b00;
    exp_ovs = 2'b00;
    exp_outp = 2'b00;
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    test_stray();
    send_word({4'h8, 4'h7}, {4'h8, 4'h9}, -1, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back(input int words, input int rand_max);
    for (int w = 0; w < words; w++)
      send_word(8'($urandom), 8'($urandom), -1, 0, rand_max, 1'b0);
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_stall();
    test_abort();
    test_stray();
    test_reset_mid();
    test_back_to_back(30, 0);
    test_back_to_back(40, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
